// File: rtl/mips_mc_main_fsm.sv
// Multicycle MIPS main controller: one state register, control
// outputs decoded combinationally from the current state.
module mips_mc_main_fsm #(
    parameter bit HAS_ADDI = 1'b1,
    parameter bit HAS_BNE  = 1'b1,
    parameter bit HAS_JUMP = 1'b1,
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       Branch,
    output logic       BranchNe,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    state_t state;
    logic   rdy;
    logic   is_r;
    logic   is_mem;
    logic   is_br;
    logic   is_addi;
    logic   is_j;

    // Without wait support every memory access finishes in one cycle.
    assign rdy = MEM_WAIT ? mem_ready : 1'b1;

    assign is_r    = (opcode == OP_R);
    assign is_mem  = (opcode == OP_LW) || (opcode == OP_SW);
    assign is_br   = (opcode == OP_BEQ) || (HAS_BNE && (opcode == OP_BNE));
    assign is_addi = HAS_ADDI && (opcode == OP_ADDI);
    assign is_j    = HAS_JUMP && (opcode == OP_J);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            unique case (state)
                S_FETCH:    if (rdy) state <= S_DECODE;
                S_DECODE: begin
                    unique case (1'b1)
                        is_r:    state <= S_EXECUTE;
                        is_mem:  state <= S_MEMADR;
                        is_br:   state <= S_BRANCH;
                        is_addi: state <= S_ADDIEX;
                        is_j:    state <= S_JUMP;
                        default: state <= S_TRAP;
                    endcase
                end
                S_MEMADR:   state <= (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (rdy) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (rdy) state <= S_FETCH;
                S_EXECUTE:  state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_ADDIEX:   state <= S_ADDIWB;
                S_ADDIWB:   state <= S_FETCH;
                S_JUMP:     state <= S_FETCH;
                default:    state <= S_TRAP;
            endcase
        end
    end

    always_comb begin
        IorD       = 1'b0;
        ALUSrcA    = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        Branch     = 1'b0;
        BranchNe   = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        illegal_op = 1'b0;
        unique case (state)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = rdy;
                PCWrite = rdy;
            end
            S_DECODE:   ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD:  IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSrc    = 2'b01;
                Branch   = (opcode == OP_BEQ);
                BranchNe = (opcode == OP_BNE);
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB:   RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            default:    illegal_op = 1'b1;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_mips_mc_main_fsm.sv
// Bench for mips_mc_main_fsm: a full-featured waiting instance and a
// stripped no-wait instance, checked against per-opcode state paths.
module tb_mips_mc_main_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] opcode2 = 6'h00;
    logic       mem_ready = 1'b0;
    logic       mem_ready2 = 1'b0;

    logic       iord1, srca1, irw1, pcw1, memw1, regw1, rdst1, m2r1, br1, bne1, ill1;
    logic [1:0] srcb1, aluop1, pcsrc1;
    logic [3:0] st1;
    logic       iord2, srca2, irw2, pcw2, memw2, regw2, rdst2, m2r2, br2, bne2, ill2;
    logic [1:0] srcb2, aluop2, pcsrc2;
    logic [3:0] st2;
    logic [16:0] o1, o2;

    int n_cmp = 0;
    int n_err = 0;
    int cnt_s3 = 0;
    int cnt_mwb = 0;

    logic [5:0] m1_op = 6'h00;
    logic [5:0] m2_op = 6'h00;
    int m1_idx = 0;
    int m2_idx = 0;

    always #5 clk = ~clk;

    mips_mc_main_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .IorD(iord1), .ALUSrcA(srca1), .IRWrite(irw1), .PCWrite(pcw1),
        .MemWrite(memw1), .RegWrite(regw1), .RegDst(rdst1), .MemtoReg(m2r1),
        .Branch(br1), .BranchNe(bne1), .ALUSrcB(srcb1), .ALUOp(aluop1),
        .PCSrc(pcsrc1), .illegal_op(ill1), .state_o(st1)
    );

    mips_mc_main_fsm #(
        .HAS_ADDI(1'b0), .HAS_BNE(1'b0), .HAS_JUMP(1'b0), .MEM_WAIT(1'b0)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode2), .mem_ready(mem_ready2),
        .IorD(iord2), .ALUSrcA(srca2), .IRWrite(irw2), .PCWrite(pcw2),
        .MemWrite(memw2), .RegWrite(regw2), .RegDst(rdst2), .MemtoReg(m2r2),
        .Branch(br2), .BranchNe(bne2), .ALUSrcB(srcb2), .ALUOp(aluop2),
        .PCSrc(pcsrc2), .illegal_op(ill2), .state_o(st2)
    );

    assign o1 = {iord1, srca1, irw1, pcw1, memw1, regw1, rdst1, m2r1,
                 br1, bne1, srcb1, aluop1, pcsrc1, ill1};
    assign o2 = {iord2, srca2, irw2, pcw2, memw2, regw2, rdst2, m2r2,
                 br2, bne2, srcb2, aluop2, pcsrc2, ill2};

    // State visited at step i of an instruction; -1 once it is done.
    function automatic int path_state(logic [5:0] op, int i, bit full);
        int p[6];
        p = '{0, 1, 12, -1, -1, -1};
        if (op == 6'h00) p = '{0, 1, 6, 7, -1, -1};
        else if (op == 6'h23) p = '{0, 1, 2, 3, 4, -1};
        else if (op == 6'h2B) p = '{0, 1, 2, 5, -1, -1};
        else if (op == 6'h04) p = '{0, 1, 8, -1, -1, -1};
        else if (op == 6'h05 && full) p = '{0, 1, 8, -1, -1, -1};
        else if (op == 6'h08 && full) p = '{0, 1, 9, 10, -1, -1};
        else if (op == 6'h02 && full) p = '{0, 1, 11, -1, -1, -1};
        return (i < 6) ? p[i] : -1;
    endfunction

    function automatic logic [5:0] pick(bit full);
        logic [5:0] ops[7];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02};
        return full ? ops[$urandom_range(0, 6)] : ops[$urandom_range(0, 3)];
    endfunction

    function automatic logic [16:0] exp_out(int s, logic [5:0] op, bit rdy);
        logic iord, srca, irw, pcw, memw, regw, rdst, m2r, br, bne, ill;
        logic [1:0] srcb, aluop, pcsrc;
        {iord, srca, irw, pcw, memw, regw, rdst, m2r, br, bne, ill} = '0;
        srcb = 2'd0; aluop = 2'd0; pcsrc = 2'd0;
        case (s)
            0: begin srcb = 2'd1; irw = rdy; pcw = rdy; end
            1: srcb = 2'd3;
            2: begin srca = 1'b1; srcb = 2'd2; end
            3: iord = 1'b1;
            4: begin m2r = 1'b1; regw = 1'b1; end
            5: begin iord = 1'b1; memw = 1'b1; end
            6: begin srca = 1'b1; aluop = 2'd2; end
            7: begin rdst = 1'b1; regw = 1'b1; end
            8: begin
                srca = 1'b1; aluop = 2'd1; pcsrc = 2'd1;
                br = (op == 6'h04); bne = (op == 6'h05);
            end
            9: begin srca = 1'b1; srcb = 2'd2; end
            10: regw = 1'b1;
            11: begin pcsrc = 2'd2; pcw = 1'b1; end
            default: ill = 1'b1;
        endcase
        return {iord, srca, irw, pcw, memw, regw, rdst, m2r, br, bne,
                srcb, aluop, pcsrc, ill};
    endfunction

    // Memory states wait for ready; the trap state never leaves.
    function automatic void adv(inout logic [5:0] op, inout int idx,
                                input bit rdy, input bit full);
        int s;
        s = path_state(op, idx, full);
        if (s == 12) return;
        if ((s == 0 || s == 3 || s == 5) && !rdy) return;
        idx++;
        if (path_state(op, idx, full) < 0) begin
            idx = 0;
            op = pick(full);
        end
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit mr);
        int s1, s2;
        @(negedge clk);
        mem_ready = mr;
        opcode = m1_op;
        opcode2 = m2_op;
        #1;
        s1 = path_state(m1_op, m1_idx, 1'b1);
        s2 = path_state(m2_op, m2_idx, 1'b0);
        chk("state1", 32'(st1), 32'(s1));
        chk("outs1", 32'(o1), 32'(exp_out(s1, m1_op, mr)));
        chk("state2", 32'(st2), 32'(s2));
        chk("outs2", 32'(o2), 32'(exp_out(s2, m2_op, 1'b1)));
        if (st1 == 4'd3) cnt_s3++;
        if (regw1 && m2r1) cnt_mwb++;
        adv(m1_op, m1_idx, mr, 1'b1);
        adv(m2_op, m2_idx, 1'b1, 1'b0);
    endtask

    // Reset is applied between edges so its effect must be asynchronous.
    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("rst_state1", 32'(st1), 32'd0);
        chk("rst_state2", 32'(st2), 32'd0);
        chk("rst_outs1", 32'(o1), 32'(exp_out(0, opcode, 1'b0)));
        chk("rst_outs2", 32'(o2), 32'(exp_out(0, opcode2, 1'b1)));
        chk("rst_memwrite", 32'(memw1), 32'd0);
        chk("rst_illegal", 32'(ill1), 32'd0);
        m1_idx = 0;
        m2_idx = 0;
        m1_op = pick(1'b1);
        m2_op = pick(1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 400; i++) cycle($urandom_range(0, 2) != 0);

        do_reset();
        m1_op = 6'h00;
        for (int i = 0; i < 5; i++) cycle(1'b1);

        do_reset();
        m1_op = 6'h23;
        cnt_s3 = 0;
        cnt_mwb = 0;
        cycle(1'b1); cycle(1'b1); cycle(1'b1);
        cycle(1'b0); cycle(1'b0); cycle(1'b0);
        cycle(1'b1); cycle(1'b1);
        chk("lw_memread_cycles", 32'(cnt_s3), 32'd4);
        chk("lw_memwb_once", 32'(cnt_mwb), 32'd1);

        do_reset();
        m1_op = 6'h05;
        m2_op = 6'h05;
        for (int i = 0; i < 6; i++) cycle(1'b1);
        chk("bne_trap_held", 32'(ill2), 32'd1);

        do_reset();
        m1_op = 6'h02;
        for (int i = 0; i < 4; i++) cycle(1'b1);

        do_reset();
        m1_op = 6'h2B;
        cycle(1'b1); cycle(1'b1); cycle(1'b1);
        cycle(1'b0); cycle(1'b0);
        chk("sw_stalled", 32'(st1), 32'd5);
        do_reset();

        m2_op = 6'h2B;
        for (int i = 0; i < 4; i++) cycle(1'b0);
        @(posedge clk);
        #1;
        chk("sw_nowait_done", 32'(st2), 32'd0);

        do_reset();
        m1_op = 6'h3F;
        m2_op = 6'h08;
        for (int i = 0; i < 6; i++) cycle($urandom_range(0, 1) != 0);
        chk("trap_illegal", 32'(ill1), 32'd1);
        do_reset();
        for (int i = 0; i < 40; i++) cycle($urandom_range(0, 2) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_mc_main_fsm.md
MIPS_MC_MAIN_FSM -- requirements
Module: mips_mc_main_fsm

Interface
REQ-001 SHALL have parameter HAS_ADDI, default 1: 1 decodes ADDI (0x08); 0 makes it illegal.
REQ-002 SHALL have parameter HAS_BNE, default 1: 1 decodes BNE (0x05); 0 makes it illegal.
REQ-003 SHALL have parameter HAS_JUMP, default 1: 1 decodes J (0x02); 0 makes it illegal.
REQ-004 SHALL have parameter MEM_WAIT, default 1: 1 honours mem_ready; 0 treats mem_ready as constant 1.
REQ-005 SHALL have port clk, input, 1 bit: clock, rising-edge active.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port opcode, input, 6 bits: IR[31:26], stable from DECODE until return to FETCH.
REQ-008 SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-009 SHALL have outputs IorD, ALUSrcA, IRWrite, PCWrite, MemWrite, RegWrite, RegDst, MemtoReg, Branch, BranchNe, each 1 bit.
REQ-010 SHALL have outputs ALUSrcB, ALUOp and PCSrc, each 2 bits.
REQ-011 SHALL have output illegal_op (1 bit, trap flag) and output state_o (4 bits, current state code).

Function
REQ-012 SHALL encode states as FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=12.
REQ-013 SHALL treat codes 13-15 as TRAP.
REQ-014 SHALL hold state in a single register; outputs SHALL be combinational from state (plus mem_ready where stated).
REQ-015 SHALL drive every output not listed for a state to 0; outputs SHALL never be X.
REQ-016 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite=PCWrite=mem_ready.
REQ-017 FETCH SHALL stay in FETCH while mem_ready=0 and SHALL go to DECODE when mem_ready=1.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
REQ-019 DECODE SHALL branch on opcode: 0x00->EXECUTE; 0x23 or 0x2B->MEMADR; 0x04->BRANCH; 0x05->BRANCH if HAS_BNE; 0x08->ADDIEX if HAS_ADDI; 0x02->JUMP if HAS_JUMP; any other opcode->TRAP.
REQ-020 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEMREAD if opcode=0x23, else MEMWRITE.
REQ-021 MEMREAD: IorD=1; SHALL hold while mem_ready=0, then go to MEMWB.
REQ-022 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-023 MEMWRITE: IorD=1, MemWrite=1 every cycle in state; SHALL hold while mem_ready=0, then go to FETCH.
REQ-024 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next ALUWB.
REQ-025 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
REQ-026 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01; Branch=(opcode==0x04), BranchNe=(opcode==0x05); next FETCH; PC enable combining with zero SHALL be external.
REQ-027 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next ADDIWB.
REQ-028 ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
REQ-029 JUMP: PCSrc=10, PCWrite=1; next FETCH.
REQ-030 TRAP: illegal_op=1, all write enables 0; SHALL stay in TRAP until reset.
REQ-031 mem_ready SHALL be ignored in every state except FETCH, MEMREAD and MEMWRITE.
REQ-032 Stall length SHALL be unbounded; there SHALL be no timeout.
REQ-033 Cycle counts with zero wait: R-type 4, LW 5, SW 4, BEQ/BNE 3, ADDI 4, J 3.
REQ-034 state_o SHALL equal the state register.

Reset
REQ-035 rst_n=0 SHALL force state=FETCH asynchronously, mid-instruction or mid-stall included; outputs SHALL take FETCH values immediately.
REQ-036 illegal_op SHALL clear on reset.
REQ-037 On release, the first FETCH SHALL still wait for mem_ready=1.

Verification
REQ-038 Reset, mem_ready=1, opcode=0x00 -> state_o 0,1,6,7,0; RegWrite=1 only in state 7 with RegDst=1.
REQ-039 opcode=0x23, mem_ready=0 for 3 cycles in MEMREAD -> state_o stays 3 for 3 cycles; MemWB RegWrite=1 with MemtoReg=1 once.
REQ-040 opcode=0x05 with HAS_BNE=1 -> BRANCH with BranchNe=1, Branch=0, PCSrc=01; with HAS_BNE=0 -> TRAP, illegal_op=1 and held.
REQ-041 opcode=0x02 -> state_o 0,1,11,0; PCWrite=1, PCSrc=10 in JUMP.
REQ-042 rst_n pulsed low in MEMWRITE with mem_ready=0 -> state_o=0, MemWrite=0 immediately.
REQ-043 MEM_WAIT=0 with mem_ready tied 0 -> SW completes in 4 cycles.
